// File: rtl/uart_fifo_bridge_pkg.sv
// uart_fifo_bridge_pkg
//   Shared definitions for the buffered uart front-end: FSM state encodings,
//   CPU status bit positions and uart core status bit positions.
package uart_fifo_bridge_pkg;

    typedef enum logic [1:0] {
        S_STAT = 2'd0,
        S_DEC  = 2'd1,
        S_RXRD = 2'd2,
        S_TXWR = 2'd3
    } state_t;

    // CPU-visible status register (a0 = 0) bit positions
    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_OVR   = 2;
    localparam int ST_TX_DROP  = 3;

    // uart core status bit positions (u_dout when u_a0 = 0)
    localparam int CORE_RXFULL = 0;
    localparam int CORE_TXBUSY = 1;

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with a combinational head output.
//   Push while full and pop while empty are ignored. A simultaneous push and
//   pop both take effect and leave the count unchanged.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   push_i       write wdata_i this cycle
//   pop_i        discard the head this cycle
//   wdata_i      write data
//   rdata_o      head entry (valid when not empty)
//   empty_o      no entries
//   full_o       2^DEPTH_LOG2 entries
//   count_o      number of entries, DEPTH_LOG2+1 bits
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Fullness is judged on the current count, so a push while full is
    // dropped even if a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge
//   Buffered front-end between the CPU bus and the single-byte uart core.
//   The CPU sees the core's two-address window (a0=0 status, a0=1 data)
//   backed by a TX FIFO and an RX FIFO; a polling FSM is the sole master of
//   the core register port.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   cs, rnw, a0, din    CPU access (one push/pop per rising edge of cs)
//   dout                CPU read data, combinational
//   u_cs, u_rnw, u_a0   core register port controls (registered)
//   u_din               core write data (registered)
//   u_dout              core read data: status or rx byte
//
// FSM states
//   state  | meaning
//   S_STAT | read core status, latch {tx_busy, rx_full} into st
//   S_DEC  | decide on latched status: RX first, then TX, else poll again
//   S_RXRD | read rx byte from core, push into RX FIFO (drop if full)
//   S_TXWR | write TX FIFO head to core, pop TX FIFO
module uart_fifo_bridge
    import uart_fifo_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rnw,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       u_cs,
    output logic       u_rnw,
    output logic       u_a0,
    output logic [7:0] u_din,
    input  logic [7:0] u_dout
);

    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t              state_q;
    logic [1:0]          st_q;
    logic                cs_q;
    logic                rx_ovr_q, tx_drop_q;
    logic                u_cs_q, u_rnw_q, u_a0_q;
    logic [7:0]          u_din_q;

    logic                acc;
    logic                tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0]          tx_rdata, rx_rdata;
    logic                tx_empty, tx_full, rx_empty, rx_full;
    logic [DEPTH_LOG2:0] tx_count, rx_count;
    logic [7:0]          status;

    assign acc = cs & ~cs_q;

    assign tx_push = acc & ~rnw & a0 & ~tx_full;
    assign rx_pop  = acc &  rnw & a0 & ~rx_empty;
    assign rx_push = (state_q == S_RXRD) & ~rx_full;
    assign tx_pop  = (state_q == S_TXWR);

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (din),
        .rdata_o (tx_rdata),
        .empty_o (tx_empty),
        .full_o  (tx_full),
        .count_o (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (u_dout),
        .rdata_o (rx_rdata),
        .empty_o (rx_empty),
        .full_o  (rx_full),
        .count_o (rx_count)
    );

    always_comb begin
        status              = 8'h00;
        status[ST_RX_AVAIL] = (rx_count != '0);
        status[ST_TX_FULL]  = (tx_count == FULL_CNT);
        status[ST_RX_OVR]   = rx_ovr_q;
        status[ST_TX_DROP]  = tx_drop_q;
        if (a0) dout = rx_empty ? 8'h00 : rx_rdata;
        else    dout = status;
    end

    // Sticky error flags; a set in the same cycle as a CPU clear wins so
    // the event is not lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_q      <= 1'b0;
            rx_ovr_q  <= 1'b0;
            tx_drop_q <= 1'b0;
        end else begin
            cs_q <= cs;
            if (acc && !rnw && !a0) begin
                rx_ovr_q  <= 1'b0;
                tx_drop_q <= 1'b0;
            end
            if ((state_q == S_RXRD) && rx_full) rx_ovr_q  <= 1'b1;
            if (acc && !rnw && a0 && tx_full)    tx_drop_q <= 1'b1;
        end
    end

    // Outputs are loaded on entry to a state so they hold for that state's
    // whole cycle; the core samples on both edges.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_STAT;
            st_q    <= 2'b00;
            u_cs_q  <= 1'b0;
            u_rnw_q <= 1'b1;
            u_a0_q  <= 1'b0;
            u_din_q <= 8'h00;
        end else begin
            case (state_q)
                S_STAT: begin
                    st_q    <= u_dout[1:0];
                    state_q <= S_DEC;
                end
                S_DEC: begin
                    if (st_q[CORE_RXFULL]) begin
                        state_q <= S_RXRD;
                        u_cs_q  <= 1'b1;
                        u_a0_q  <= 1'b1;
                        u_rnw_q <= 1'b1;
                    end else if (!st_q[CORE_TXBUSY] && !tx_empty) begin
                        state_q <= S_TXWR;
                        u_cs_q  <= 1'b1;
                        u_a0_q  <= 1'b1;
                        u_rnw_q <= 1'b0;
                        u_din_q <= tx_rdata;
                    end else begin
                        state_q <= S_STAT;
                    end
                end
                S_RXRD, S_TXWR: begin
                    state_q <= S_STAT;
                    u_cs_q  <= 1'b0;
                    u_a0_q  <= 1'b0;
                    u_rnw_q <= 1'b1;
                end
            endcase
        end
    end

    assign u_cs  = u_cs_q;
    assign u_rnw = u_rnw_q;
    assign u_a0  = u_a0_q;
    assign u_din = u_din_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
module tb_uart_fifo_bridge;
    import uart_fifo_bridge_pkg::*;

    logic       clk;
    logic       reset;
    logic       cs, rnw, a0;
    logic [7:0] din, dout;
    logic       u_cs, u_rnw, u_a0;
    logic [7:0] u_din, u_dout;

    // core model state
    logic       rx_full_m, tx_busy_m;
    logic [7:0] rx_byte_m;
    logic       core_rd;
    logic [7:0] rx_src [$];
    logic [7:0] exp_tx [$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tx_seen = 0, rx_reads = 0;
    int tx_cyc = 0, rx_cyc = 0;

    typedef struct {
        logic       wr;
        logic       a0;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [$];

    uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .cs     (cs),
        .rnw    (rnw),
        .a0     (a0),
        .din    (din),
        .dout   (dout),
        .u_cs   (u_cs),
        .u_rnw  (u_rnw),
        .u_a0   (u_a0),
        .u_din  (u_din),
        .u_dout (u_dout)
    );

    assign u_dout = u_a0 ? rx_byte_m : {6'b0, tx_busy_m, rx_full_m};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: observe the core port at negedge, then advance the core
    // model just after posedge.
    task automatic tick();
        @(negedge clk);
        if (u_cs && u_a0 && u_rnw) begin
            rx_reads++;
            rx_cyc  = cyc;
            core_rd = 1'b1;
        end
        if (u_cs && u_a0 && !u_rnw) begin
            tx_seen++;
            tx_cyc = cyc;
            if (exp_tx.size() == 0) chk("tx_unexpected", {24'h0, u_din}, 32'hffff_ffff);
            else                    chk("tx_byte", {24'h0, u_din}, {24'h0, exp_tx.pop_front()});
        end
        @(posedge clk);
        cyc++;
        #1;
        if (core_rd) begin
            rx_full_m = 1'b0;
            core_rd   = 1'b0;
        end
        if (!rx_full_m && rx_src.size() > 0) begin
            rx_byte_m = rx_src.pop_front();
            rx_full_m = 1'b1;
        end
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] d, input int len, output int acc_cyc);
        cs = 1'b1; rnw = 1'b0; a0 = a; din = d;
        tick();
        acc_cyc = cyc;
        repeat (len - 1) tick();
        cs = 1'b0;
        tick();
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] d);
        cs = 1'b0; rnw = 1'b1; a0 = a;
        #2;
        d = dout;
        cs = 1'b1;
        tick();
        cs = 1'b0;
        tick();
    endtask

    task automatic run_vecs(input string name);
        logic [7:0] r;
        int         dummy;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) cpu_write(vecs[i].a0, vecs[i].data, 1, dummy);
            else begin
                cpu_read(vecs[i].a0, r);
                chk($sformatf("%s[%0d]", name, i), {24'h0, r}, {24'h0, vecs[i].exp});
            end
        end
        vecs.delete();
    endtask

    function automatic vec_t mk(input logic wr, input logic a, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.wr = wr; v.a0 = a; v.data = d; v.exp = e;
        return v;
    endfunction

    initial begin
        logic [7:0] r;
        int acc_c, base, n;

        reset = 1'b0; cs = 1'b0; rnw = 1'b1; a0 = 1'b0; din = 8'h00;
        rx_full_m = 1'b0; tx_busy_m = 1'b0; rx_byte_m = 8'h00; core_rd = 1'b0;

        // reset held two cycles
        tick(); tick();
        a0 = 1'b0; #1; chk("rst_status", {24'h0, dout}, 32'h00);
        a0 = 1'b1; #1; chk("rst_data", {24'h0, dout}, 32'h00);
        chk("rst_u_cs", {31'h0, u_cs}, 32'h0);
        chk("rst_u_rnw", {31'h0, u_rnw}, 32'h1);
        chk("rst_u_a0", {31'h0, u_a0}, 32'h0);
        chk("rst_u_din", {24'h0, u_din}, 32'h00);
        chk("rst_state", {30'h0, dut.state_q}, {30'h0, S_STAT});
        reset = 1'b1;
        repeat (12) tick();
        chk("idle_tx", tx_seen, 0);
        chk("idle_rx", rx_reads, 0);

        // single TX byte, cs held 3 cycles
        exp_tx.push_back(8'h41);
        cpu_write(1'b1, 8'h41, 3, acc_c);
        n = 0;
        while (tx_seen < 1 && n < 20) begin tick(); n++; end
        chk("tx1_seen", tx_seen, 1);
        chk("tx1_latency_ok", {31'h0, (tx_cyc - acc_c) <= 4}, 32'h1);
        repeat (10) tick();
        chk("tx1_once", tx_seen, 1);
        chk("tx1_fifo_empty", {31'h0, dut.u_tx_fifo.empty_o}, 32'h1);

        // single RX byte
        rx_src.push_back(8'h5A);
        n = 0;
        while (rx_reads < 1 && n < 20) begin tick(); n++; end
        chk("rx1_reads", rx_reads, 1);
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h01));
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h5A));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00));
        run_vecs("rx1");

        // TX overflow while core busy
        tx_busy_m = 1'b1;
        repeat (4) tick();
        base = tx_seen;
        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mk(1'b1, 1'b1, 8'(i), 8'h00));
            exp_tx.push_back(8'(i));
        end
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h02));
        vecs.push_back(mk(1'b1, 1'b1, 8'h10, 8'h00));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h0A));
        run_vecs("txovf");
        chk("txovf_held", tx_seen, base);
        tx_busy_m = 1'b0;
        n = 0;
        while (tx_seen < base + 16 && n < 200) begin tick(); n++; end
        chk("txovf_drained", tx_seen, base + 16);
        repeat (10) tick();
        chk("txovf_no_extra", tx_seen, base + 16);
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h08));
        run_vecs("txovf_st");

        // RX overflow with no CPU reads
        base = rx_reads;
        for (int i = 0; i < 17; i++) rx_src.push_back(8'h80 + 8'(i));
        n = 0;
        while ((rx_reads < base + 17 || rx_full_m) && n < 300) begin tick(); n++; end
        chk("rxovf_reads", rx_reads, base + 17);
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h0D));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h01));
        for (int i = 0; i < 16; i++) vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h80 + 8'(i)));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h00));
        run_vecs("rxovf");

        // RX priority over TX in the same poll
        tx_busy_m = 1'b1;
        repeat (4) tick();
        exp_tx.push_back(8'h77);
        cpu_write(1'b1, 8'h77, 1, acc_c);
        repeat (4) tick();
        base = tx_seen;
        n = rx_reads;
        rx_byte_m = 8'h33; rx_full_m = 1'b1; tx_busy_m = 1'b0;
        acc_c = 0;
        while (tx_seen < base + 1 && acc_c < 20) begin tick(); acc_c++; end
        chk("prio_tx", tx_seen, base + 1);
        chk("prio_rx", rx_reads, n + 1);
        chk("prio_gap", tx_cyc - rx_cyc, 3);
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h33));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00));
        run_vecs("prio");
        chk("exp_tx_empty", exp_tx.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
